// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: control pins from the top level plus the counter's pins, as seen by the sequencer.
// The master side is the surrounding environment: pin decode and the counter instance.
interface counter_sequencer_if #(parameter int WIDTH = 8);
   logic             start;
   logic             stop;
   logic             auto_reload;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] end_val;
   logic [WIDTH-1:0] cnt_out;
   logic             cnt_load;
   logic             cnt_en;
   logic [WIDTH-1:0] cnt_in;
   logic             busy;
   logic             tick;
   logic             done;
   logic [WIDTH-1:0] period_cnt;
   modport master (
      output start, stop, auto_reload, start_val, end_val, cnt_out,
      input  cnt_load, cnt_en, cnt_in, busy, tick, done, period_cnt
   );
   modport slave (
      input  start, stop, auto_reload, start_val, end_val, cnt_out,
      output cnt_load, cnt_en, cnt_in, busy, tick, done, period_cnt
   );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: loads the up-counter, counts it to an end value, then stops or reloads periodically.
module counter_sequencer #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   counter_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] start_q, end_q, period_q;
   logic             auto_q, tick_q;
   logic             match, hit, accept;
   logic             load, en, done;
   assign match  = state_q == RUN && bus.cnt_out == end_q;
   // a stop in the match cycle cancels the period: no tick, no count
   assign hit    = match && !bus.stop;
   assign accept = state_q == IDLE && bus.start && !bus.stop;
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      en      = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: state_d = accept ? LOAD : IDLE;
         LOAD: begin
            load    = 1'b1;
            state_d = bus.stop ? IDLE : RUN;
         end
         RUN: begin
            en      = !match && !bus.stop;
            state_d = bus.stop ? IDLE : match ? (auto_q ? LOAD : DONE) : RUN;
         end
         default: begin
            done    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         start_q  <= '0;
         end_q    <= '0;
         auto_q   <= 1'b0;
         period_q <= '0;
         tick_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= hit;
         if (accept) begin
            start_q  <= bus.start_val;
            end_q    <= bus.end_val;
            auto_q   <= bus.auto_reload;
            period_q <= '0;
         end else if (hit && period_q != '1) begin
            period_q <= period_q + WIDTH'(1);
         end
      end
   end
   assign bus.cnt_load   = load;
   assign bus.cnt_en     = en;
   assign bus.cnt_in     = start_q;
   assign bus.busy       = state_q != IDLE;
   assign bus.tick       = tick_q;
   assign bus.done       = done;
   assign bus.period_cnt = period_q;
endmodule
